// File: rtl/tap_pulse_gen.sv
// TAP cassette image player for the PET: reads a TAP image from RAM byte by byte
// and turns each decoded pulse length into a square wave on the cassette read line.
module tap_pulse_gen #(
   parameter int unsigned HDR_LEN = 20,
   parameter int unsigned VER_OFS = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_1m,
   input  logic        load,
   input  logic [24:0] image_end,
   input  logic        pause,
   output logic        rd,
   output logic [24:0] addr,
   input  logic [7:0]  din,
   input  logic        ready,
   output logic        audio,
   output logic        active
);

   localparam int unsigned AW = 25;
   localparam int unsigned TW = 24;
   localparam logic [AW-1:0] HDR_ADDR = AW'(HDR_LEN);
   localparam logic [AW-1:0] VER_ADDR = AW'(VER_OFS);

   typedef enum logic [1:0] {S_IDLE, S_VER, S_PLAY, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          load_q;
   logic [AW-1:0] img_end_q;
   logic          v1_q;
   logic [TW-1:0] buf_len_q;
   logic          buf_valid_q;
   logic [1:0]    ext_cnt_q;
   logic [15:0]   ext_acc_q;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] lo_len_q;
   logic          running_q;

   logic          load_fall;
   logic          rd_done;
   logic          bytes_left;
   logic          rd_issue;
   logic          play_tick;
   logic          pulse_end;
   logic [TW-1:0] tmr_dec;
   logic [TW-1:0] dec_len;
   logic [TW-1:0] fill_len;
   logic          dec_fill;
   logic [1:0]    ext_cnt_d;
   logic [15:0]   ext_acc_d;

   assign load_fall  = load_q & ~load;
   assign rd_done    = rd & ready;
   assign bytes_left = addr < img_end_q;
   assign play_tick  = ce_1m & ~pause & (state_q == S_PLAY);
   assign pulse_end  = ~running_q | (timer_q == '0);
   assign tmr_dec    = timer_q - TW'(1);

   // Next state; load high overrides everything and parks the player in IDLE
   always_comb begin
      state_d  = state_q;
      rd_issue = 1'b0;
      if (load) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (load_fall) state_d = S_VER;
            S_VER: begin
               rd_issue = ~rd & ~pause;
               if (rd_done) state_d = (img_end_q <= HDR_ADDR) ? S_DONE : S_PLAY;
            end
            S_PLAY: begin
               rd_issue = ~rd & ~pause & ~buf_valid_q & bytes_left;
               if (~running_q & ~buf_valid_q & ~rd & ~bytes_left) state_d = S_DONE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Byte decoder: plain bytes, v0 zero marker, or three-byte v1 extended length
   always_comb begin
      dec_len   = '0;
      dec_fill  = 1'b0;
      ext_cnt_d = ext_cnt_q;
      ext_acc_d = ext_acc_q;
      if (ext_cnt_q == 2'd0) begin
         if (din != 8'd0) begin
            dec_len  = TW'({din, 3'b000});
            dec_fill = 1'b1;
         end else if (!v1_q) begin
            dec_len  = TW'(2048);
            dec_fill = 1'b1;
         end else begin
            ext_cnt_d = 2'd1;
         end
      end else if (ext_cnt_q == 2'd3) begin
         dec_len   = {din, ext_acc_q};
         dec_fill  = 1'b1;
         ext_cnt_d = 2'd0;
      end else begin
         if (ext_cnt_q == 2'd1) ext_acc_d[7:0]  = din;
         else                   ext_acc_d[15:8] = din;
         ext_cnt_d = ext_cnt_q + 2'd1;
      end
      fill_len = (dec_len < TW'(2)) ? TW'(2) : dec_len;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         load_q      <= 1'b0;
         img_end_q   <= '0;
         v1_q        <= 1'b0;
         buf_len_q   <= '0;
         buf_valid_q <= 1'b0;
         ext_cnt_q   <= '0;
         ext_acc_q   <= '0;
         timer_q     <= '0;
         lo_len_q    <= '0;
         running_q   <= 1'b0;
         rd          <= 1'b0;
         addr        <= '0;
         audio       <= 1'b0;
         active      <= 1'b0;
      end else begin
         state_q <= state_d;
         load_q  <= load;
         active  <= (state_d == S_VER) || (state_d == S_PLAY);
         if (load) begin
            rd          <= 1'b0;
            audio       <= 1'b0;
            running_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            timer_q     <= '0;
            ext_cnt_q   <= '0;
         end else begin
            if (load_fall) begin
               img_end_q <= image_end;
               addr      <= VER_ADDR;
               v1_q      <= 1'b0;
            end

            if (rd_done)       rd <= 1'b0;
            else if (rd_issue) rd <= 1'b1;

            // Pulse timer: counts down L-1..0, audio high while above the low-phase length
            if (play_tick) begin
               if (pulse_end) begin
                  if (buf_valid_q) begin
                     timer_q     <= buf_len_q - TW'(1);
                     lo_len_q    <= buf_len_q - (buf_len_q >> 1);
                     running_q   <= 1'b1;
                     audio       <= 1'b1;
                     buf_valid_q <= 1'b0;
                  end else begin
                     running_q <= 1'b0;
                     audio     <= 1'b0;
                  end
               end else begin
                  timer_q <= tmr_dec;
                  audio   <= (tmr_dec >= lo_len_q);
               end
            end

            if (rd_done && state_q == S_VER) begin
               v1_q <= din[0];
               addr <= HDR_ADDR;
            end else if (rd_done && state_q == S_PLAY) begin
               addr      <= addr + AW'(1);
               ext_cnt_q <= ext_cnt_d;
               ext_acc_q <= ext_acc_d;
               if (dec_fill) begin
                  buf_len_q   <= fill_len;
                  buf_valid_q <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tap_pulse_gen.sv
// Bench for tap_pulse_gen: RAM responder, tick generator, audio run-length monitor
// checked against a pulse list parsed from the image bytes.
module tb_tap_pulse_gen;

   localparam int HDR = 20;

   logic        clk = 1'b0;
   logic        reset, ce_1m, load, pause, rd, ready, audio, active;
   logic [24:0] image_end, addr;
   logic [7:0]  din;

   always #5 clk = ~clk;

   tap_pulse_gen #(.HDR_LEN(20), .VER_OFS(12)) dut (
      .clk(clk), .reset(reset), .ce_1m(ce_1m), .load(load), .image_end(image_end),
      .pause(pause), .rd(rd), .addr(addr), .din(din), .ready(ready),
      .audio(audio), .active(active)
   );

   int          total = 0;
   int          bad = 0;
   logic [7:0]  mem [0:255];
   logic [7:0]  img [$];
   int          exp_q [$];
   int          ce_div = 4;
   int          rdy_delay = 0;
   bit          mon_en = 1'b0;
   int          n_reads = 0;
   logic [24:0] last_rd_addr = '0;
   int          audio_rises = 0;
   int          budget_cyc = 0;

   task automatic check(input string nm, input longint act, input longint expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic close_run(input bit is_hi, input int n);
      int e;
      e = -1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check(is_hi ? "high_run" : "low_run", n, e);
   endtask

   // Tick generator: one-cycle ce_1m every ce_div clocks
   initial begin
      int cnt;
      cnt = 0;
      ce_1m = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (cnt >= ce_div - 1) begin cnt = 0; ce_1m = 1'b1; end
         else begin cnt++; ce_1m = 1'b0; end
      end
   end

   // RAM model: answers each rd after rdy_delay cycles with a one-cycle ready
   initial begin
      int w;
      w = 0;
      ready = 1'b0;
      din = 8'd0;
      forever begin
         @(posedge clk); #1;
         if (ready) begin
            ready = 1'b0;
            w = 0;
         end else if (rd) begin
            if (w >= rdy_delay) begin
               ready = 1'b1;
               din = mem[addr[7:0]];
               n_reads++;
               last_rd_addr = addr;
               w = 0;
            end else w++;
         end else w = 0;
      end
   end

   initial forever begin
      @(posedge audio);
      audio_rises++;
   end

   // Monitor: level seen just before each tick edge, grouped into high/low runs
   initial begin
      int hi, lo;
      bit in_hi, seen;
      hi = 0; lo = 0; in_hi = 0; seen = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            hi = 0; lo = 0; in_hi = 0; seen = 0;
         end else if (ce_1m) begin
            if (active && audio) begin
               if (!in_hi && lo > 0) begin close_run(1'b0, lo); lo = 0; end
               in_hi = 1; seen = 1; hi++;
            end else if (active) begin
               if (in_hi) begin close_run(1'b1, hi); hi = 0; in_hi = 0; end
               if (seen) lo++;
            end else begin
               if (in_hi) begin close_run(1'b1, hi); hi = 0; in_hi = 0; end
               if (lo > 0) begin close_run(1'b0, lo); lo = 0; end
               seen = 0;
            end
         end
      end
   end

   // Reference: walk the image bytes and list (high, low) tick counts per pulse
   task automatic model(input int nbytes, input bit v1);
      int i, last, b, len, sum;
      i = HDR; last = HDR + nbytes; sum = 0;
      while (i < last) begin
         b = int'(mem[i]);
         i++;
         if (b != 0) len = 8 * b;
         else if (!v1) len = 2048;
         else begin
            if (last - i < 3) break;
            len = int'(mem[i]) + 256 * int'(mem[i+1]) + 65536 * int'(mem[i+2]);
            i += 3;
         end
         if (len < 2) len = 2;
         exp_q.push_back(len / 2);
         exp_q.push_back(len - len / 2);
         sum += len;
      end
      budget_cyc = sum * ce_div + 1000;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_image(input logic [7:0] ver_byte, input int cdiv, input int dly);
      mon_en = 1'b0;
      load = 1'b1;
      pause = 1'b0;
      exp_q.delete();
      ce_div = cdiv;
      rdy_delay = dly;
      mem[12] = ver_byte;
      foreach (img[k]) mem[HDR + k] = img[k];
      image_end = 25'(HDR + img.size());
      model(img.size(), ver_byte[0]);
      cycles(3);
      n_reads = 0;
      audio_rises = 0;
      load = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic wait_active(input logic lvl, input int budget, input string nm);
      int n;
      n = 0;
      while (active !== lvl && n < budget) begin cycles(1); n++; end
      check(nm, active, lvl);
   endtask

   task automatic wait_audio_hi(input int budget);
      int n;
      n = 0;
      while (audio !== 1'b1 && n < budget) begin cycles(1); n++; end
      check("audio_start", audio, 1);
   endtask

   task automatic finish_image();
      wait_active(1'b1, 20, "active_on");
      wait_active(1'b0, budget_cyc, "active_off");
      cycles(2 * ce_div + 4);
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int n, ext, nb;
      bit v1;
      reset = 1'b1; load = 1'b0; pause = 1'b0; image_end = '0;
      cycles(3);
      check("rst_rd", rd, 0);
      check("rst_addr", addr, 0);
      check("rst_audio", audio, 0);
      check("rst_active", active, 0);
      reset = 1'b0;
      cycles(10);
      check("idle_active", active, 0);
      check("idle_rd", rd, 0);

      // v0 single pulse 0x30
      img = '{8'h30};
      start_image(8'h00, 2, 0);
      finish_image();

      // v0 zero byte
      img = '{8'h00};
      start_image(8'h00, 2, 1);
      finish_image();

      // v1 extended pulse of 5000 ticks
      img = '{8'h00, 8'h88, 8'h13, 8'h00};
      start_image(8'h01, 2, 0);
      finish_image();

      // back-to-back, slow RAM, ce every 8 clocks
      img = '{8'h02, 8'h03};
      start_image(8'h00, 8, 5);
      finish_image();

      // pause for 50 ticks starting at tick 100 of a 384-tick pulse
      img = '{8'h30};
      start_image(8'h00, 2, 0);
      exp_q[0] = exp_q[0] + 50;
      budget_cyc += 200;
      wait_audio_hi(200);
      n = 0;
      while (n < 100) begin if (ce_1m) n++; cycles(1); end
      pause = 1'b1;
      n = 0;
      while (n < 50) begin if (ce_1m) n++; cycles(1); end
      pause = 1'b0;
      finish_image();

      // load pulse while a read is outstanding mid-PLAY
      img = '{8'h30, 8'h20};
      start_image(8'h00, 2, 5);
      wait_audio_hi(200);
      n = 0;
      while (rd !== 1'b1 && n < 50) begin cycles(1); n++; end
      check("abort_rd_pending", rd, 1);
      mon_en = 1'b0;
      load = 1'b1;
      cycles(1);
      check("abort_audio", audio, 0);
      check("abort_rd", rd, 0);
      check("abort_active", active, 0);
      img = '{8'h04};
      start_image(8'h00, 4, 2);
      finish_image();

      // image_end equal to header length
      img.delete();
      start_image(8'h01, 4, 1);
      finish_image();
      check("deg_reads", n_reads, 1);
      check("deg_addr", last_rd_addr, 12);
      check("deg_audio_edges", audio_rises, 0);

      // truncated v1 extended pulse is dropped
      img = '{8'h05, 8'h00, 8'h10, 8'h20};
      start_image(8'hA1, 4, 2);
      finish_image();

      // extended length below 2 clamps to 2
      img = '{8'h00, 8'h01, 8'h00, 8'h00};
      start_image(8'h01, 4, 0);
      finish_image();

      // randomized images
      for (int r = 0; r < 6; r++) begin
         v1 = 1'($urandom);
         img.delete();
         nb = 3 + int'($urandom % 4);
         for (int j = 0; j < nb; j++) begin
            if (v1 && ($urandom % 4) == 0) begin
               ext = 100 + int'($urandom % 200);
               img.push_back(8'h00);
               img.push_back(8'(ext));
               img.push_back(8'(ext >> 8));
               img.push_back(8'h00);
            end else begin
               img.push_back(8'(1 + ($urandom % 16)));
            end
         end
         if (v1 && ($urandom % 3) == 0) begin
            img.push_back(8'h00);
            img.push_back(8'($urandom));
         end
         start_image({7'($urandom), v1}, 4 + int'($urandom % 3), int'($urandom % 4));
         finish_image();
      end

      // asynchronous reset in the middle of a pulse
      img = '{8'h10};
      start_image(8'h00, 2, 0);
      wait_audio_hi(200);
      mon_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("arst_audio", audio, 0);
      check("arst_active", active, 0);
      check("arst_rd", rd, 0);
      check("arst_addr", addr, 0);
      cycles(3);
      reset = 1'b0;
      cycles(10);
      check("arst_stay_idle", active, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tap_pulse_gen.md
TAP_PULSE_GEN -- requirements
Module: tap_pulse_gen

Interface
REQ-001 Parameter HDR_LEN, default 20: TAP header length in bytes; pulse data starts at address HDR_LEN.
REQ-002 Parameter VER_OFS, default 12: byte offset of the TAP version byte.
REQ-003 Ports; clk and reset are listed first. One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 ce_1m  in  1  CPU-rate tick; every pulse timer advances only on this enable.
REQ-007 load  in  1  image download in progress; forces IDLE while high.
REQ-008 image_end  in  25  image length in bytes; sampled on the falling edge of load.
REQ-009 pause  in  1  freezes playback while high.
REQ-010 rd  out  1  RAM read request.
REQ-011 addr  out  25  RAM byte address.
REQ-012 din  in  8  RAM read data; valid only in a cycle where ready=1.
REQ-013 ready  in  1  RAM read completion.
REQ-014 audio  out  1  cassette read level to the PET hardware.
REQ-015 active  out  1  playback in progress.

Function
REQ-016 States: IDLE, VER, PLAY, DONE.
- IDLE -> VER on the falling edge of load.
- VER -> PLAY once the version byte is read.
- PLAY -> DONE when the image is exhausted.
- DONE -> IDLE on a rising edge of load.
REQ-017 Read handshake:
- rd rises with addr stable and stays high until ready=1 is sampled.
- din is captured in the ready cycle.
- rd is low the following cycle.
- At most one read is outstanding.
REQ-018 VER reads the byte at VER_OFS. Bit 0 selects v1 format (1) or v0 format (0). Bits 7:1 are ignored.
REQ-019 Data fetch starts at HDR_LEN; addr increments by 1 per captured byte.
- No read is issued at addr >= image_end.
REQ-020 Pulse length L, in ce_1m ticks:
- byte N != 0: L = 8*N.
- zero byte, v0: L = 2048.
- zero byte, v1: L = the next three bytes as a 24-bit little-endian value.
REQ-021 If the computed L < 2, L = 2.
REQ-022 Output waveform per pulse:
- audio=1 for floor(L/2) ticks, then 0 for L - floor(L/2) ticks.
- The next pulse starts on the tick after the last one, with no gap.
REQ-023 Prefetch:
- One decoded-pulse buffer (length register plus valid flag).
- Fetching and decoding of the next pulse overlap the current pulse.
- If the buffer is empty when the current pulse ends, audio holds 0 and the timer stalls until the buffer is valid.
REQ-024 A v1 extended pulse truncated by image_end (fewer than 3 bytes remain) is discarded; the block goes to DONE.
REQ-025 Image exhausted: PLAY -> DONE after the final pulse completes and no more bytes remain.
REQ-026 If image_end <= HDR_LEN, the block goes VER -> DONE with no pulses; audio stays 0.
REQ-027 While pause=1:
- the pulse timer and phase freeze and audio holds its value;
- an in-flight read completes and fills the buffer;
- no new read is issued.
REQ-028 load rising in any state:
- the next cycle: IDLE, audio=0, active=0, buffer invalid;
- an outstanding rd drops and the pending ready is ignored.
REQ-029 ce_1m and ready in the same cycle: both are processed in that cycle.
REQ-030 active=1 in VER and PLAY, 0 in IDLE and DONE. It is registered.
REQ-031 The timer width is 24 bits. The sampled image_end is held constant until the next falling edge of load.

Reset
REQ-032 While reset is asserted:
- state=IDLE, rd=0, addr=0, audio=0, active=0;
- buffer invalid; timer=0; v1 flag=0; sampled image_end=0.
REQ-033 After reset release, nothing happens until a falling edge of load.

Verification
REQ-034 v0 single pulse: image_end=21, byte12=0x00, byte20=0x30 -> audio high 192 ticks, low 192 ticks, then DONE with active=0.
REQ-035 v0 zero byte: byte20=0x00 -> audio high 1024 ticks, then low 1024 ticks.
REQ-036 v1 extended pulse: byte12=0x01, bytes20..23=00 10 27 00, image_end=24 -> high 5000 ticks, low 5000 ticks.
REQ-037 Back-to-back pulses: bytes 0x02,0x03, ready delayed 5 clk per read, ce_1m every 8 clk -> high 8 / low 8 / high 12 / low 12 ticks, no stall ticks.
REQ-038 Pause: pause=1 for 50 ticks at tick 100 of a 384-tick pulse -> audio frozen, pulse ends at tick 434; load pulse mid-PLAY -> next cycle IDLE, audio=0, rd=0.
REQ-039 Degenerate inputs: image_end=20 -> one read at addr 12 only, then DONE, no audio edges; reset asserted mid-pulse -> all outputs 0 immediately.
